pixel_coord_tagger: RTL and testbench

- Ready/valid pixel-stream stage that tags each accepted pixel with its raster coordinates (x, y), start-of-frame, end-of-line and end-of-frame flags, plus a running frame count.
- Sits directly upstream of the line-buffer and window stages, and supplies the column/row position those stages would otherwise count themselves.
- Provides a two-entry skid buffer, so throughput is one pixel per cycle with registered `ready_o`.

---
 rtl/pixel_coord_tagger.sv | 128 ++++++++++++
 tb/tb_pixel_coord_tagger.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pixel_coord_tagger.sv
// Ready/valid pixel stage that tags each accepted pixel with raster (x, y), frame
// flags and a frame index, buffered through a two-entry skid so ready_o is registered.
module pixel_coord_tagger #(
    parameter int DataWidth  = 8,
    parameter int CoordWidth = 10,
    parameter int FrameWidth = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [CoordWidth-1:0] width_i,
    input  logic [CoordWidth-1:0] height_i,
    input  logic                  sync_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DataWidth-1:0]  data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DataWidth-1:0]  data_o,
    output logic [CoordWidth-1:0] x_o,
    output logic [CoordWidth-1:0] y_o,
    output logic                  sof_o,
    output logic                  eol_o,
    output logic                  eof_o,
    output logic [FrameWidth-1:0] frame_cnt_o
);

    typedef struct packed {
        logic [DataWidth-1:0]  data;
        logic [CoordWidth-1:0] x;
        logic [CoordWidth-1:0] y;
        logic                  sof;
        logic                  eol;
        logic                  eof;
        logic [FrameWidth-1:0] frame;
    } tag_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

    state_e                state_q, nx_state;
    logic                  ready_q, valid_q;
    tag_t                  main_q, skid_q, tag;
    logic [CoordWidth-1:0] x_q, y_q, base_x, base_y, nx_x, nx_y;
    logic [FrameWidth-1:0] f_q, base_f, nx_f;
    logic                  acc, take;

    assign acc  = valid_i && ready_q;
    assign take = valid_q && ready_i;

    // A sync restarts the raster before the pixel is tagged, whether or not one is accepted.
    always_comb begin
        base_x   = sync_i ? '0 : x_q;
        base_y   = sync_i ? '0 : y_q;
        base_f   = sync_i ? f_q + 1'b1 : f_q;
        tag.data = data_i;
        tag.x    = base_x;
        tag.y    = base_y;
        tag.eol  = base_x >= width_i;
        tag.eof  = (base_x >= width_i) && (base_y >= height_i);
        tag.sof  = (base_x == '0) && (base_y == '0);
        tag.frame = base_f;
        nx_x = base_x;
        nx_y = base_y;
        nx_f = base_f;
        if (acc) begin
            // >= rather than == keeps a mid-frame shrink to a single wrap.
            if (base_x < width_i) begin
                nx_x = base_x + 1'b1;
            end else begin
                nx_x = '0;
                if (base_y < height_i) begin
                    nx_y = base_y + 1'b1;
                end else begin
                    nx_y = '0;
                    nx_f = base_f + 1'b1;
                end
            end
        end
    end

    always_comb begin
        nx_state = state_q;
        case (state_q)
            EMPTY:   if (acc) nx_state = ONE;
            ONE:     if (acc && !take) nx_state = TWO;
                     else if (take && !acc) nx_state = EMPTY;
            TWO:     if (take) nx_state = ONE;
            default: nx_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            f_q     <= '0;
        end else begin
            state_q <= nx_state;
            ready_q <= nx_state != TWO;
            valid_q <= nx_state != EMPTY;
            x_q     <= nx_x;
            y_q     <= nx_y;
            f_q     <= nx_f;
            case (state_q)
                EMPTY:   if (acc) main_q <= tag;
                ONE:     if (acc && take) main_q <= tag;
                         else if (acc) skid_q <= tag;
                TWO:     if (take) main_q <= skid_q;
                default: ;
            endcase
        end
    end

    assign ready_o     = ready_q;
    assign valid_o     = valid_q;
    assign data_o      = main_q.data;
    assign x_o         = main_q.x;
    assign y_o         = main_q.y;
    assign sof_o       = main_q.sof;
    assign eol_o       = main_q.eol;
    assign eof_o       = main_q.eof;
    assign frame_cnt_o = main_q.frame;

endmodule

// File: tb/tb_pixel_coord_tagger.sv
// Directed plus randomized checks of pixel_coord_tagger against a queue-based raster model.
module tb_pixel_coord_tagger;
    localparam int DW = 8, CW = 10, FW = 2, FM = 1 << FW;

    logic          clk = 1'b0;
    logic          rst_n, sync_i, valid_i, ready_i, ready_o, valid_o;
    logic          sof_o, eol_o, eof_o;
    logic [CW-1:0] width_i, height_i, x_o, y_o;
    logic [DW-1:0] data_i, data_o;
    logic [FW-1:0] frame_cnt_o;

    pixel_coord_tagger #(.DataWidth(DW), .CoordWidth(CW), .FrameWidth(FW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .width_i(width_i), .height_i(height_i),
        .sync_i(sync_i), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .x_o(x_o), .y_o(y_o),
        .sof_o(sof_o), .eol_o(eol_o), .eof_o(eof_o), .frame_cnt_o(frame_cnt_o));

    always #5 clk = ~clk;

    typedef struct {int d, x, y, sof, eol, eof, f;} pix_t;
    pix_t q[$];
    int   mx, my, mf, exp_rdy, was_rst;
    int   errors = 0, checks = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, note handshakes, advance model at the edge, check on negedge.
    task automatic cyc(input logic v, input logic s, input logic r, input logic rn);
        logic acc, take;
        pix_t p;
        int   bx, by, bf, w, h;
        valid_i = v; sync_i = s; ready_i = r; rst_n = rn; data_i = DW'($urandom);
        #1;
        acc  = v && ready_o;
        take = valid_o && r;
        w = int'(width_i); h = int'(height_i);
        @(posedge clk);
        if (!rn) begin
            q.delete(); mx = 0; my = 0; mf = 0; exp_rdy = 0; was_rst = 1;
        end else begin
            was_rst = 0;
            if (take && q.size() > 0) void'(q.pop_front());
            if (acc) begin
                bx = s ? 0 : mx; by = s ? 0 : my; bf = s ? (mf + 1) % FM : mf;
                p.d = int'(data_i); p.x = bx; p.y = by; p.f = bf;
                p.eol = int'(bx >= w); p.eof = int'(bx >= w && by >= h);
                p.sof = int'(bx == 0 && by == 0);
                q.push_back(p);
                if (bx < w) begin mx = bx + 1; my = by; end
                else if (by < h) begin mx = 0; my = by + 1; end
                else begin mx = 0; my = 0; bf = (bf + 1) % FM; end
                mf = bf;
            end else if (s) begin
                mx = 0; my = 0; mf = (mf + 1) % FM;
            end
            exp_rdy = int'(q.size() < 2);
        end
        @(negedge clk);
        chk("valid_o", valid_o, q.size() > 0);
        chk("ready_o", ready_o, exp_rdy);
        if (was_rst)
            chk("reset_outputs", {data_o, x_o, y_o, sof_o, eol_o, eof_o, frame_cnt_o}, 0);
        if (q.size() > 0) begin
            chk("data_o", data_o, q[0].d);
            chk("x_o", x_o, q[0].x);
            chk("y_o", y_o, q[0].y);
            chk("sof_o", sof_o, q[0].sof);
            chk("eol_o", eol_o, q[0].eol);
            chk("eof_o", eof_o, q[0].eof);
            chk("frame_cnt_o", frame_cnt_o, q[0].f);
        end
    endtask

    task automatic do_reset(input int w, input int h);
        width_i = CW'(w); height_i = CW'(h);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
    endtask

    initial begin
        rst_n = 0; sync_i = 0; valid_i = 0; ready_i = 0; data_i = '0;
        width_i = '0; height_i = '0;
        @(negedge clk);

        // Basic raster: 4x2 frame, two frames streamed back to back.
        do_reset(3, 1);
        cyc(0, 0, 1, 1);
        for (int i = 0; i < 16; i++) cyc(1, 0, 1, 1);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);

        // Backpressure: skid fills, ready_o drops, outputs hold, then drain in order.
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1);

        // Resync without a coincident accept at (2,1), then with one.
        do_reset(3, 1);
        cyc(0, 0, 1, 1);
        for (int i = 0; i < 6; i++) cyc(1, 0, 1, 1);
        cyc(0, 1, 1, 1);
        cyc(1, 0, 1, 1);
        for (int i = 0; i < 5; i++) cyc(1, 0, 1, 1);
        cyc(1, 1, 1, 1);
        cyc(1, 0, 1, 1);
        cyc(0, 0, 1, 1);
        cyc(0, 1, 1, 1);
        cyc(0, 1, 1, 1);
        cyc(1, 0, 1, 1);
        cyc(0, 0, 1, 1);

        // Degenerate 1x1 frames: every pixel is sof/eol/eof, frame wraps after 4.
        do_reset(0, 0);
        cyc(0, 0, 1, 1);
        for (int i = 0; i < 5; i++) cyc(1, 0, 1, 1);
        cyc(0, 0, 1, 1);

        // Reset while the skid holds two pixels.
        do_reset(3, 1);
        cyc(0, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 1);
        cyc(1, 0, 1, 1);
        cyc(0, 0, 1, 1);

        // Shrink width from 7 to 3 while x sits at 5.
        do_reset(7, 3);
        cyc(0, 0, 1, 1);
        for (int i = 0; i < 5; i++) cyc(1, 0, 1, 1);
        width_i = CW'(3);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 1);
        cyc(0, 0, 1, 1);

        // Randomized traffic with occasional sync and size changes.
        do_reset(2, 2);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                width_i  = CW'($urandom_range(0, 5));
                height_i = CW'($urandom_range(0, 3));
            end
            cyc(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 29) == 0),
                logic'($urandom_range(0, 2) != 0), 1'b1);
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
